// File: rtl/wb_lift53_pkg.sv
// wb_lift53_pkg: register map, engine FSM states and the 5/3 lifting step shared by wb_lift53.
package wb_lift53_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned INTER_W  = 18;

    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_STATUS = 1;

    localparam int unsigned CTRL_N_W       = 16;
    localparam int unsigned CTRL_START_BIT = 16;
    localparam int unsigned CTRL_IE_BIT    = 17;
    localparam int unsigned CTRL_INV_BIT   = 18;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;

    localparam logic signed [INTER_W-1:0] ROUND_UPD = INTER_W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_CALC,
        S_WR,
        S_DONE
    } lift_state_t;

    // One lifting step on centre c with neighbours l/r; sign of the correction
    // flips between predict/update and again for the inverse transform.
    function automatic logic [SAMPLE_W-1:0] lift_step(
        input logic                is_update,
        input logic                is_inverse,
        input logic [SAMPLE_W-1:0] l,
        input logic [SAMPLE_W-1:0] c,
        input logic [SAMPLE_W-1:0] r
    );
        logic signed [INTER_W-1:0] sl;
        logic signed [INTER_W-1:0] sc;
        logic signed [INTER_W-1:0] sr;
        logic signed [INTER_W-1:0] delta;
        logic signed [INTER_W-1:0] res;
        sl = {{(INTER_W-SAMPLE_W){l[SAMPLE_W-1]}}, l};
        sc = {{(INTER_W-SAMPLE_W){c[SAMPLE_W-1]}}, c};
        sr = {{(INTER_W-SAMPLE_W){r[SAMPLE_W-1]}}, r};
        if (is_update) begin
            delta = (sl + sr + ROUND_UPD) >>> 2;
        end else begin
            delta = (sl + sr) >>> 1;
        end
        res = (is_update ^ is_inverse) ? (sc + delta) : (sc - delta);
        return SAMPLE_W'(res);
    endfunction

endpackage

// File: rtl/wb_lift53_ram.sv
// wb_lift53_ram: single-port synchronous sample RAM, 2^(AW-1) x 16, one-cycle read latency.
module wb_lift53_ram
    import wb_lift53_pkg::*;
#(
    parameter int unsigned AW = 11
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [AW-2:0]       i_addr,
    input  logic [SAMPLE_W-1:0] i_wdata,
    output logic [SAMPLE_W-1:0] o_rdata
);

    logic [SAMPLE_W-1:0] r_mem [0:(1<<(AW-1))-1];
    logic [SAMPLE_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_lift53.sv
// wb_lift53: Wishbone slave holding one sample row and running an in-place 5/3 lifting pass.
// Optional inverse transform is built when WB_LIFT53_INVERSE_EN is defined.
module wb_lift53
    import wb_lift53_pkg::*;
#(
    parameter int unsigned AW = 11
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [31:0]   i_wb_data,
    output logic          o_wb_ack,
    output logic          o_wb_stall,
    output logic          o_wb_err,
    output logic [31:0]   o_wb_data,
    output logic          o_int
);

    localparam int unsigned RAM_DEPTH = 1 << (AW-1);

    // Bus decode
    logic                w_req;
    logic                w_sel_ram;
    logic [AW-2:0]       w_reg_off;
    logic                w_is_ctrl;
    logic                w_is_status;
    logic [CTRL_N_W-1:0] w_new_n;
    logic                w_new_inv;
    logic                w_n_legal;
    logic                w_start_req;
    logic                w_start_ok;
    logic [31:0]         w_ctrl_word;
    logic [31:0]         w_status_word;
    logic                w_unused;

    // Registers
    logic                r_ack;
    logic                r_err;
    logic                r_rd_ram;
    logic [31:0]         r_reg_rdata;
    logic [CTRL_N_W-1:0] r_ctrl_n;
    logic                r_ctrl_ie;
    logic                r_ctrl_inv;
    logic                r_busy;
    logic                r_done;
    logic                r_int;

    // Engine
    lift_state_t         r_state;
    lift_state_t         w_next_state;
    logic [15:0]         r_idx;
    logic                r_second;
    logic [CTRL_N_W-1:0] r_run_n;
    logic                r_run_inv;
    logic [SAMPLE_W-1:0] r_l;
    logic [SAMPLE_W-1:0] r_c;
    logic [SAMPLE_W-1:0] r_res;
    logic                w_upd;
    logic                w_last;
    logic [15:0]         w_left;
    logic [15:0]         w_right;
    logic [15:0]         w_eng_sel;
    logic                w_eng_we;
    logic                w_finish;

    // RAM port
    logic [AW-2:0]       w_ram_addr;
    logic                w_ram_we;
    logic [SAMPLE_W-1:0] w_ram_wdata;
    logic [SAMPLE_W-1:0] w_ram_rdata;

    assign w_req       = i_wb_cyc & i_wb_stb;
    assign w_sel_ram   = i_wb_addr[AW-1];
    assign w_reg_off   = i_wb_addr[AW-2:0];
    assign w_is_ctrl   = ~w_sel_ram & (w_reg_off == (AW-1)'(REG_CTRL));
    assign w_is_status = ~w_sel_ram & (w_reg_off == (AW-1)'(REG_STATUS));
    assign w_new_n     = i_wb_data[CTRL_N_W-1:0];
`ifdef WB_LIFT53_INVERSE_EN
    assign w_new_inv   = i_wb_data[CTRL_INV_BIT];
`else
    assign w_new_inv   = 1'b0;
`endif
    assign w_n_legal   = ~w_new_n[0] && (w_new_n >= 16'd4) && (32'(w_new_n) <= RAM_DEPTH);
    assign w_start_req = w_req & i_wb_we & w_is_ctrl & i_wb_data[CTRL_START_BIT];
    assign w_start_ok  = w_start_req & ~r_busy & w_n_legal;
    assign w_unused    = &{1'b0, i_wb_data[31:19], i_wb_data[CTRL_INV_BIT]};

    always_comb begin
        w_ctrl_word                   = '0;
        w_ctrl_word[CTRL_N_W-1:0]     = r_ctrl_n;
        w_ctrl_word[CTRL_IE_BIT]      = r_ctrl_ie;
        w_ctrl_word[CTRL_INV_BIT]     = r_ctrl_inv;
        w_status_word                 = '0;
        w_status_word[STATUS_BUSY_BIT] = r_busy;
        w_status_word[STATUS_DONE_BIT] = r_done;
    end

    // Bus side: responses, CTRL/STATUS, busy/done and interrupt
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_rd_ram    <= 1'b0;
            r_reg_rdata <= '0;
            r_ctrl_n    <= '0;
            r_ctrl_ie   <= 1'b0;
            r_ctrl_inv  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_int       <= 1'b0;
        end else begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_rd_ram <= 1'b0;
            r_int    <= r_done & r_ctrl_ie;
            if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_req) begin
                if (w_sel_ram) begin
                    if (r_busy) begin
                        r_err <= 1'b1;
                    end else begin
                        r_ack    <= 1'b1;
                        r_rd_ram <= ~i_wb_we;
                    end
                end else if (w_is_ctrl) begin
                    if (w_start_req && !w_start_ok) begin
                        r_err <= 1'b1;
                    end else begin
                        r_ack       <= 1'b1;
                        r_reg_rdata <= w_ctrl_word;
                        if (i_wb_we) begin
                            r_ctrl_n   <= w_new_n;
                            r_ctrl_ie  <= i_wb_data[CTRL_IE_BIT];
                            r_ctrl_inv <= w_new_inv;
                        end
                        if (w_start_ok) begin
                            r_busy <= 1'b1;
                            r_done <= 1'b0;
                        end
                    end
                end else if (w_is_status) begin
                    r_ack       <= 1'b1;
                    r_reg_rdata <= w_status_word;
                    // A completion in this same cycle keeps done set
                    if (i_wb_we && i_wb_data[STATUS_DONE_BIT] && !w_finish) begin
                        r_done <= 1'b0;
                    end
                end else begin
                    r_ack       <= 1'b1;
                    r_reg_rdata <= '0;
                end
            end
        end
    end

    assign o_wb_ack   = r_ack;
    assign o_wb_err   = r_err;
    assign o_wb_stall = 1'b0;
    assign o_int      = r_int;
    assign o_wb_data  = r_rd_ram ? {{(32-SAMPLE_W){w_ram_rdata[SAMPLE_W-1]}}, w_ram_rdata}
                                 : r_reg_rdata;

    // Engine pass selection and neighbour addresses with mirrored edges
    assign w_upd   = r_second ^ r_run_inv;
    assign w_last  = ({1'b0, r_idx} + 17'd2) >= {1'b0, r_run_n};
    assign w_left  = (r_idx == 16'd0) ? 16'd1 : (r_idx - 16'd1);
    assign w_right = ((r_idx + 16'd1) == r_run_n) ? (r_run_n - 16'd2) : (r_idx + 16'd1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_eng_sel    = r_idx;
        w_eng_we     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: w_next_state = w_start_ok ? S_RD0 : S_IDLE;
            S_RD0: begin
                w_eng_sel    = w_left;
                w_next_state = S_RD1;
            end
            S_RD1: w_next_state = S_RD2;
            S_RD2: begin
                w_eng_sel    = w_right;
                w_next_state = S_CALC;
            end
            S_CALC: w_next_state = S_WR;
            S_WR: begin
                w_eng_we = 1'b1;
                if (!w_last || !r_second) begin
                    w_next_state = S_RD0;
                end else begin
                    w_next_state = S_DONE;
                    w_finish     = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx     <= '0;
            r_second  <= 1'b0;
            r_run_n   <= '0;
            r_run_inv <= 1'b0;
            r_l       <= '0;
            r_c       <= '0;
            r_res     <= '0;
        end else begin
            if (w_start_ok) begin
                r_run_n   <= w_new_n;
                r_run_inv <= w_new_inv;
                r_second  <= 1'b0;
                r_idx     <= w_new_inv ? 16'd0 : 16'd1;
            end
            case (r_state)
                S_RD1:  r_l   <= w_ram_rdata;
                S_RD2:  r_c   <= w_ram_rdata;
                S_CALC: r_res <= lift_step(w_upd, r_run_inv, r_l, r_c, w_ram_rdata);
                S_WR: begin
                    if (!w_last) begin
                        r_idx <= r_idx + 16'd2;
                    end else if (!r_second) begin
                        r_second <= 1'b1;
                        r_idx    <= r_run_inv ? 16'd1 : 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (r_busy) begin
            w_ram_addr  = w_eng_sel[AW-2:0];
            w_ram_we    = w_eng_we;
            w_ram_wdata = r_res;
        end else begin
            w_ram_addr  = w_reg_off;
            w_ram_we    = w_req & i_wb_we & w_sel_ram;
            w_ram_wdata = i_wb_data[SAMPLE_W-1:0];
        end
    end

    wb_lift53_ram #(
        .AW(AW)
    ) u_ram (
        .i_clk  (i_clk),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_ram_rdata)
    );

endmodule
